// File: rtl/wbs_reg_bank_pkg.sv
// Shared types and constants for the WISHBONE register bank.
package wbs_reg_bank_pkg;

  // Responder FSM states. The encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wbs_state_e;

  // Register index width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wbs_reg_bank_if.sv
// WISHBONE classic device-side bus bundle for the register bank.
//
// Handshake: the host raises wb_cyc_i and wb_stb_i together with
// wb_we_i/wb_adr_i/wb_dat_i/wb_sel_i and holds all of them stable until it
// sees a one-cycle wb_ack_o (normal) or wb_err_o (unmapped address). Exactly
// one of them pulses per completed transfer. Dropping wb_cyc_i or wb_stb_i
// before termination abandons the transfer with no side effects. wb_dat_o is
// only meaningful in the cycle wb_ack_o is high for a read, and is 0 otherwise.
interface wbs_reg_bank_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic [ADDRESS_WIDTH-1:0]  wb_adr_i;
  logic [DATA_WIDTH-1:0]     wb_dat_i;
  logic [DATA_WIDTH/8-1:0]   wb_sel_i;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic [DATA_WIDTH-1:0]     wb_dat_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/wbs_byte_reg.sv
// One bank register with per-byte write enables and a reset value.
module wbs_byte_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic [DATA_WIDTH-1:0]   i_dat,
  output logic [DATA_WIDTH-1:0]   o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  // Update only the enabled byte lanes on a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VALUE;
    end else if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_sel[b]) r_q[b*8 +: 8] <= i_dat[b*8 +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wbs_reg_bank.sv
// WISHBONE classic responder terminating the bus in a bank of byte-writable
// registers, with programmable wait states and error on unmapped addresses.
module wbs_reg_bank
  import wbs_reg_bank_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 16,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_REGS      = 16,
  parameter int                    WAIT_STATES   = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_n_i,
  wbs_reg_bank_if.slave                  wb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            wr_strobe_o,
  output wbs_state_e                     dbg_state_o
);

  localparam int                     IDX_W      = clog2_min1(NUM_REGS);
  localparam logic [7:0]             WAIT_LOAD  = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
  // One extra bit so NUM_REGS == 2^ADDRESS_WIDTH is still representable.
  localparam logic [ADDRESS_WIDTH:0] NUM_REGS_W = (ADDRESS_WIDTH+1)'(NUM_REGS);

  wbs_state_e            r_state;
  wbs_state_e            w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic                  w_req;
  logic                  w_commit;
  logic                  w_mapped;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_REGS-1:0]   w_onehot;
  logic [NUM_REGS-1:0]   w_reg_we;
  logic [DATA_WIDTH-1:0] w_reg_q [NUM_REGS];

  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [NUM_REGS-1:0]   r_strobe;

  assign w_req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_mapped = ({1'b0, wb.wb_adr_i} < NUM_REGS_W);
  assign w_idx    = wb.wb_adr_i[IDX_W-1:0];

  // State and wait counter registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; w_commit marks the edge that enters RESP and samples the bus.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address decode: one-hot register select and read mux.
  always_comb begin
    w_onehot  = '0;
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_rd_data   = w_reg_q[k];
      end
    end
  end

  assign w_reg_we = (w_commit & wb.wb_we_i & w_mapped) ? w_onehot : '0;

  // Registered response: ack/err, read data and write strobes for one cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_strobe <= '0;
    end else begin
      r_ack    <= w_commit & w_mapped;
      r_err    <= w_commit & ~w_mapped;
      r_dat    <= (w_commit & ~wb.wb_we_i & w_mapped) ? w_rd_data : '0;
      r_strobe <= w_reg_we;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    wbs_byte_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_n_i),
      .i_we    (w_reg_we[g]),
      .i_sel   (wb.wb_sel_i),
      .i_dat   (wb.wb_dat_i),
      .o_q     (w_reg_q[g])
    );
    assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = w_reg_q[g];
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign wr_strobe_o = r_strobe;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wbs_reg_bank.sv
// Bench for wbs_reg_bank: two instances (0 and 3 wait states) driven by a
// WISHBONE host, checked every cycle against a transaction-level model.
module tb_wbs_reg_bank;
  import wbs_reg_bank_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NB = DW/8;
  localparam logic [DW-1:0] RV0 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] RV1 = 32'h0F0F_A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit cmp_on = 1'b1;

  // ---------------- host drive and DUT outputs ----------------
  logic          h_cyc [2];
  logic          h_stb [2];
  logic          h_we  [2];
  logic [AW-1:0] h_adr [2];
  logic [DW-1:0] h_dat [2];
  logic [NB-1:0] h_sel [2];

  logic             o_ack  [2];
  logic             o_err  [2];
  logic [DW-1:0]    o_dat  [2];
  logic [NR*DW-1:0] o_reg  [2];
  logic [NR-1:0]    o_strb [2];
  wbs_state_e       o_st   [2];

  wbs_reg_bank_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  wbs_reg_bank_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.wb_cyc_i = h_cyc[0];
  assign bus0.wb_stb_i = h_stb[0];
  assign bus0.wb_we_i  = h_we[0];
  assign bus0.wb_adr_i = h_adr[0];
  assign bus0.wb_dat_i = h_dat[0];
  assign bus0.wb_sel_i = h_sel[0];
  assign bus1.wb_cyc_i = h_cyc[1];
  assign bus1.wb_stb_i = h_stb[1];
  assign bus1.wb_we_i  = h_we[1];
  assign bus1.wb_adr_i = h_adr[1];
  assign bus1.wb_dat_i = h_dat[1];
  assign bus1.wb_sel_i = h_sel[1];

  assign o_ack[0] = bus0.wb_ack_o;
  assign o_err[0] = bus0.wb_err_o;
  assign o_dat[0] = bus0.wb_dat_o;
  assign o_ack[1] = bus1.wb_ack_o;
  assign o_err[1] = bus1.wb_err_o;
  assign o_dat[1] = bus1.wb_dat_o;

  wbs_reg_bank #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_STATES(0), .RESET_VALUE(RV0)
  ) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus0.slave),
    .reg_o(o_reg[0]), .wr_strobe_o(o_strb[0]), .dbg_state_o(o_st[0])
  );

  wbs_reg_bank #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_STATES(3), .RESET_VALUE(RV1)
  ) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus1.slave),
    .reg_o(o_reg[1]), .wr_strobe_o(o_strb[1]), .dbg_state_o(o_st[1])
  );

  // ---------------- behavioural model ----------------
  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [DW-1:0] rv_of(input int k);
    return (k == 0) ? RV0 : RV1;
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] sel);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) if (sel[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  logic [DW-1:0] m_reg  [2][NR];
  int            m_run  [2];
  bit            m_resp [2];
  bit            m_ack  [2];
  bit            m_err  [2];
  logic [DW-1:0] m_dat  [2];
  logic [NR-1:0] m_strb [2];

  function automatic logic [NR*DW-1:0] flat(input int k);
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_reg[k][i];
    return v;
  endfunction

  // A request held for WAIT_STATES+1 cycles commits; the response lasts one
  // cycle; a dropped request restarts the count.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_run[k] <= 0; m_resp[k] <= 1'b0; m_ack[k] <= 1'b0; m_err[k] <= 1'b0;
        m_dat[k] <= '0; m_strb[k] <= '0;
        for (int i = 0; i < NR; i++) m_reg[k][i] <= rv_of(k);
      end else if (m_resp[k]) begin
        m_run[k] <= 0; m_resp[k] <= 1'b0; m_ack[k] <= 1'b0; m_err[k] <= 1'b0;
        m_dat[k] <= '0; m_strb[k] <= '0;
      end else if (h_cyc[k] && h_stb[k]) begin
        if (m_run[k] == ws_of(k)) begin
          m_run[k] <= 0;
          m_resp[k] <= 1'b1;
          if (h_adr[k] < AW'(NR)) begin
            m_ack[k] <= 1'b1;
            m_err[k] <= 1'b0;
            if (h_we[k]) begin
              m_reg[k][h_adr[k][3:0]] <= (m_reg[k][h_adr[k][3:0]] & ~lane_mask(h_sel[k]))
                                        | (h_dat[k] & lane_mask(h_sel[k]));
              m_strb[k] <= NR'(1) << h_adr[k][3:0];
              m_dat[k]  <= '0;
            end else begin
              m_dat[k]  <= m_reg[k][h_adr[k][3:0]];
              m_strb[k] <= '0;
            end
          end else begin
            m_ack[k] <= 1'b0; m_err[k] <= 1'b1; m_dat[k] <= '0; m_strb[k] <= '0;
          end
        end else begin
          m_run[k] <= m_run[k] + 1;
        end
      end else begin
        m_run[k] <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ack%0d", k), 64'(o_ack[k]), 64'(m_ack[k]));
        check($sformatf("err%0d", k), 64'(o_err[k]), 64'(m_err[k]));
        check($sformatf("dat%0d", k), 64'(o_dat[k]), 64'(m_dat[k]));
        check($sformatf("strb%0d", k), 64'(o_strb[k]), 64'(m_strb[k]));
        n_checks++;
        if (o_reg[k] !== flat(k)) begin
          n_err++;
          $display("FAIL reg%0d: got %h expected %h", k, o_reg[k], flat(k));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus(input int k);
    h_cyc[k] = 1'b0; h_stb[k] = 1'b0; h_we[k] = 1'b0;
    h_adr[k] = '0; h_dat[k] = '0; h_sel[k] = '0;
  endtask

  // One full transfer; reports the cycle of termination (0 = first request cycle).
  task automatic xfer(input int k, input bit we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input logic [NB-1:0] sel,
                      output int cyc_n, output bit ack, output bit err,
                      output logic [DW-1:0] rdat, output logic [NR-1:0] strb,
                      output logic [NR*DW-1:0] regs);
    @(posedge clk); #1;
    h_cyc[k] = 1'b1; h_stb[k] = 1'b1; h_we[k] = we;
    h_adr[k] = adr; h_dat[k] = dat; h_sel[k] = sel;
    cyc_n = -1; ack = 0; err = 0; rdat = '0; strb = '0; regs = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (o_ack[k] || o_err[k]) begin
        cyc_n = n; ack = o_ack[k]; err = o_err[k];
        rdat = o_dat[k]; strb = o_strb[k]; regs = o_reg[k];
        break;
      end
    end
    if (cyc_n < 0) begin
      n_checks++; n_err++;
      $display("FAIL timeout: dut%0d no termination within 300 cycles", k);
    end
    @(posedge clk); #1;
    idle_bus(k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cn;
    bit ak, er;
    logic [DW-1:0] rd;
    logic [NR-1:0] sb;
    logic [NR*DW-1:0] rg;
    int acks;

    idle_bus(0);
    idle_bus(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values.
    for (int i = 0; i < NR; i++) begin
      check("rst_word0", 64'(o_reg[0][i*DW +: DW]), 64'(32'hDEAD_BEEF));
      check("rst_word1", 64'(o_reg[1][i*DW +: DW]), 64'(32'h0F0F_A5A5));
    end
    check("rst_ack", 64'(o_ack[0]), 64'd0);
    check("rst_err", 64'(o_err[0]), 64'd0);
    check("rst_dat", 64'(o_dat[0]), 64'd0);
    check("rst_state", 64'(o_st[0]), 64'(ST_IDLE));

    // Write then read back, no wait states.
    xfer(0, 1'b1, 16'd3, 32'h1234_5678, 4'hF, cn, ak, er, rd, sb, rg);
    check("wr_cycle", 64'(cn), 64'd1);
    check("wr_ack", 64'(ak), 64'd1);
    check("wr_strobe", 64'(sb), 64'h0008);
    check("wr_reg3", 64'(rg[3*DW +: DW]), 64'(32'h1234_5678));
    xfer(0, 1'b0, 16'd3, 32'h0, 4'h0, cn, ak, er, rd, sb, rg);
    check("rd_cycle", 64'(cn), 64'd1);
    check("rd_dat", 64'(rd), 64'(32'h1234_5678));
    check("rd_strobe", 64'(sb), 64'd0);

    // Byte lanes, including an all-lanes-off write.
    xfer(0, 1'b1, 16'd5, 32'h0, 4'hF, cn, ak, er, rd, sb, rg);
    xfer(0, 1'b1, 16'd5, 32'hAABB_CCDD, 4'b0101, cn, ak, er, rd, sb, rg);
    check("lane_reg5", 64'(rg[5*DW +: DW]), 64'(32'h00BB_00DD));
    xfer(0, 1'b1, 16'd5, 32'hFFFF_FFFF, 4'b0000, cn, ak, er, rd, sb, rg);
    check("sel0_ack", 64'(ak), 64'd1);
    check("sel0_strobe", 64'(sb), 64'h0020);
    check("sel0_reg5", 64'(rg[5*DW +: DW]), 64'(32'h00BB_00DD));

    // Unmapped address.
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF, cn, ak, er, rd, sb, rg);
    check("unm_cycle", 64'(cn), 64'd1);
    check("unm_err", 64'(er), 64'd1);
    check("unm_ack", 64'(ak), 64'd0);
    check("unm_strobe", 64'(sb), 64'd0);
    check("unm_dat", 64'(rd), 64'd0);

    // Back-to-back: request held 6 cycles yields 3 acks at zero wait states.
    @(posedge clk); #1;
    h_cyc[0] = 1'b1; h_stb[0] = 1'b1; h_we[0] = 1'b0; h_adr[0] = 16'd3; h_sel[0] = 4'hF;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (o_ack[0]) acks++;
      if (n == 5) begin @(posedge clk); #1; idle_bus(0); end
    end
    check("b2b_acks", 64'(acks), 64'd3);

    // Wait states on dut1.
    xfer(1, 1'b1, 16'd7, 32'hCAFE_F00D, 4'hF, cn, ak, er, rd, sb, rg);
    check("ws_cycle", 64'(cn), 64'd4);
    check("ws_reg7", 64'(rg[7*DW +: DW]), 64'(32'hCAFE_F00D));

    // Strobe dropped in cycle 2 of a wait-state transfer: abandoned.
    @(posedge clk); #1;
    h_cyc[1] = 1'b1; h_stb[1] = 1'b1; h_we[1] = 1'b1; h_adr[1] = 16'd7;
    h_dat[1] = 32'h1111_2222; h_sel[1] = 4'hF;
    repeat (2) @(posedge clk);
    #1 h_stb[1] = 1'b0;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (o_ack[1] || o_err[1]) acks++;
    end
    check("abort_resp", 64'(acks), 64'd0);
    check("abort_state", 64'(o_st[1]), 64'(ST_IDLE));
    check("abort_reg7", 64'(o_reg[1][7*DW +: DW]), 64'(32'hCAFE_F00D));
    idle_bus(1);

    // Randomised traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 60; t++) begin
        bit we;
        logic [AW-1:0] adr;
        we  = 1'($urandom_range(0, 1));
        adr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 65535)) : AW'($urandom_range(0, 15));
        xfer(k, we, adr, $urandom, NB'($urandom_range(0, 15)), cn, ak, er, rd, sb, rg);
        check("rnd_cycle", 64'(cn), 64'(ws_of(k) + 1));
        check("rnd_kind", 64'({ak, er}), (adr < AW'(NR)) ? 64'd2 : 64'd1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    // Reset in the middle of a wait-state transfer.
    @(posedge clk); #1;
    h_cyc[1] = 1'b1; h_stb[1] = 1'b1; h_we[1] = 1'b1; h_adr[1] = 16'd2;
    h_dat[1] = 32'h5555_AAAA; h_sel[1] = 4'hF;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ack", 64'(o_ack[1]), 64'd0);
    check("mrst_strb", 64'(o_strb[1]), 64'd0);
    check("mrst_state", 64'(o_st[1]), 64'(ST_IDLE));
    check("mrst_reg2", 64'(o_reg[1][2*DW +: DW]), 64'(32'h0F0F_A5A5));
    check("mrst_reg3_0", 64'(o_reg[0][3*DW +: DW]), 64'(32'hDEAD_BEEF));
    idle_bus(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (o_ack[1] || o_err[1]) acks++;
    end
    check("mrst_noresp", 64'(acks), 64'd0);
    check("mrst_reg2_after", 64'(o_reg[1][2*DW +: DW]), 64'(32'h0F0F_A5A5));

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
